seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//   Recovers hex digits from a multiplexed, active-low 7-segment display bus (seg + anode lines).
//   It is the receive end of the segment encoder and display driver path, used for loopback checks of the display driver.
//   Synchronises the pins, filters each digit's dwell for stability, decodes the pattern back to 4-bit hex,
//   and presents a full frame (all digits) through a valid/ready handshake.
// PARAMETERS
//   N_DIGITS       2   number of anode lines / digits per frame (1..8)
//   STABLE_CYCLES  4   consecutive identical synchronised samples required before capture (>=1)
// PORTS
//   clk            in   1           single system clock
//   rst_n          in   1           asynchronous active-low reset
//   seg_i          in   7           segment bus, active-low, {a,b,c,d,e,f,g}; bit0 = g
//   anode_i        in   N_DIGITS    digit select, active-low; anode_i[k]=0 selects digit k
//   frame_data_o   out  4*N_DIGITS  decoded digits; digit k at [4k+3:4k]
//   frame_blank_o  out  N_DIGITS    1 = digit k was blank (1111111); its data nibble = 0
//   frame_valid_o  out  1           frame available; held until accepted
//   frame_ready_i  in   1           consumer accepts when valid&&ready on a clk edge
//   pattern_err_o  out  1           1-cycle pulse: stable pattern not in the decode table
//   overrun_o      out  1           sticky: frame completed while previous one still pending; cleared only by reset
// BEHAVIOUR
//   Reset: all outputs 0, capture mask 0, FSM = WAIT, synchroniser flops 1 (bus idle = all off).
//   Input sync: 2-flop synchroniser on seg_i and anode_i. Logic uses only synchronised values.
//   Decode table (active-low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//     6=0100000 7=0001111 8=0000000 9=0001100 A=0001000 b=1100000 c=1110010 d=1000010
//     E=0110000 F=0111000. Blank=1111111 is legal (blank flag). Any other pattern is an error.
//   Sampler FSM (shared, tracks the active digit):
//     WAIT:     anode not one-hot-low (none, or >1 low) -> stay. One-hot -> TRACK; cnt=1; latch {anode,seg}.
//     TRACK:    sample == latched -> cnt++. Any change -> relatch, cnt=1. Not one-hot -> WAIT.
//               cnt reaching STABLE_CYCLES -> capture:
//                 legal pattern -> write slot k, set mask[k];
//                 illegal pattern -> pattern_err_o pulse, mask unchanged.
//               Then -> HOLD.
//     HOLD:     same sample -> stay, no recapture. Change to another one-hot -> TRACK (cnt=1). Not one-hot -> WAIT.
//   Capture latency: STABLE_CYCLES+2 clk cycles from pin change to slot write (no pins change meanwhile).
//   Slots: a recapture of digit k before the frame completes overwrites slot k (last value wins).
//   Frame complete: mask == all ones, evaluated the cycle after capture.
//     Slots copy into frame_data_o/frame_blank_o; frame_valid_o=1; mask cleared.
//     If frame_valid_o is already 1 and not accepted in that cycle: outputs are not updated,
//     the new frame is dropped, overrun_o=1, mask cleared.
//     Accept and complete in the same cycle: the new frame loads and valid stays 1 (no drop).
//   frame_data_o/frame_blank_o stay stable while frame_valid_o=1 and not accepted.
//   Reset mid-frame: the partial mask is discarded and the FSM returns to WAIT.
// STRUCTURE
//   Shared package seg7_pkg:
//     segment pattern constants SEG_0..SEG_F and SEG_BLANK, used by the existing encoder and by this block;
//     function seg_to_hex(seg) -> {legal, blank, nibble}.
//   Sub-module seg7_sync_filter: synchroniser plus sampler FSM and stability counter.
//     Emits a 1-cycle capture strobe with {digit index, seg}.
//   The top holds the slot registers, capture mask, frame output register, handshake and overrun logic.
// TESTING
//   1. N=2, ready=1.
//      Drive anode=10 seg=0010010 for 6 clk, then anode=01 seg=0000110 for 6 clk
//      -> one valid pulse, frame_data_o=8'h32, frame_blank_o=00.
//   2. Glitch: 0000001 for 2 clk then 1001111 for 6 clk on digit 0
//      -> slot 0 = 1, no capture of 0 (STABLE_CYCLES=4).
//   3. Illegal pattern 1111110 held 6 clk
//      -> pattern_err_o high exactly 1 cycle, mask unchanged, no frame.
//   4. ready=0, two complete frames 8'hA5 then 8'h0F
//      -> frame_data_o stays A5, overrun_o=1; raising ready accepts A5, valid drops.
//   5. anode=00 (both low) for 10 clk -> no capture.
//      Blank 1111111 on both digits -> frame_blank_o=11, data=00.
//   6. Assert rst_n low mid-frame, after digit 0 is captured -> all outputs 0.
//      After release, only digit 1 is driven -> no frame until digit 0 is recaptured.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns {a,b,c,d,e,f,g}
// and the pattern-to-hex decoder used by the loopback receiver.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b1110010;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {StWait, StTrack, StHold} samp_state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  // Blank is legal with a zero nibble; anything outside the table is illegal.
  function automatic seg_dec_t seg_to_hex(input logic [6:0] seg);
    seg_dec_t r;
    r.legal  = 1'b1;
    r.blank  = 1'b0;
    r.nibble = 4'h0;
    case (seg)
      SEG_0:     r.nibble = 4'h0;
      SEG_1:     r.nibble = 4'h1;
      SEG_2:     r.nibble = 4'h2;
      SEG_3:     r.nibble = 4'h3;
      SEG_4:     r.nibble = 4'h4;
      SEG_5:     r.nibble = 4'h5;
      SEG_6:     r.nibble = 4'h6;
      SEG_7:     r.nibble = 4'h7;
      SEG_8:     r.nibble = 4'h8;
      SEG_9:     r.nibble = 4'h9;
      SEG_A:     r.nibble = 4'hA;
      SEG_B:     r.nibble = 4'hB;
      SEG_C:     r.nibble = 4'hC;
      SEG_D:     r.nibble = 4'hD;
      SEG_E:     r.nibble = 4'hE;
      SEG_F:     r.nibble = 4'hF;
      SEG_BLANK: r.blank  = 1'b1;
      default:   r.legal  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_sync_filter.sv
// Pin synchroniser plus dwell-stability sampler; strobes one capture per stable
// one-hot digit dwell with the digit index and its segment pattern.
module seg7_sync_filter
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned IDX_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_i,
  input  logic [N_DIGITS-1:0] anode_i,
  output logic                cap_valid_o,
  output logic [IDX_W-1:0]    cap_idx_o,
  output logic [6:0]          cap_seg_o
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

  logic [6:0]          seg_s1_q, seg_s2_q, seg_lat_q, seg_lat_d;
  logic [N_DIGITS-1:0] an_s1_q, an_s2_q, an_lat_q, an_lat_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  samp_state_e         state_q, state_d;
  logic [N_DIGITS-1:0] sel;
  logic                one_hot, same;

  // Synchronisers idle high so the bus reads as "all off" out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg_i;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= anode_i;
      an_s2_q  <= an_s1_q;
    end
  end

  assign sel     = ~an_s2_q;
  assign one_hot = (sel != '0) && ((sel & (sel - N_DIGITS'(1))) == '0);
  assign same    = (an_s2_q == an_lat_q) && (seg_s2_q == seg_lat_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    an_lat_d    = an_lat_q;
    seg_lat_d   = seg_lat_q;
    cap_valid_o = 1'b0;
    if (!one_hot) begin
      state_d = StWait;
      cnt_d   = '0;
    end else if (!(state_q == StHold && same)) begin
      if (state_q == StTrack && same) begin
        cnt_d = cnt_q + CntW'(1);
      end else begin
        cnt_d     = CntW'(1);
        an_lat_d  = an_s2_q;
        seg_lat_d = seg_s2_q;
      end
      if (cnt_d == CntW'(STABLE_CYCLES)) begin
        cap_valid_o = 1'b1;
        state_d     = StHold;
      end else begin
        state_d = StTrack;
      end
    end
  end

  always_comb begin
    cap_idx_o = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (sel[k]) cap_idx_o = IDX_W'(k);
    end
  end

  // On a capture cycle the latch and the live sample always agree.
  assign cap_seg_o = seg_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StWait;
      cnt_q     <= '0;
      an_lat_q  <= '1;
      seg_lat_q <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      an_lat_q  <= an_lat_d;
      seg_lat_q <= seg_lat_d;
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Loopback receiver for a multiplexed 7-segment bus: collects decoded digits
// into slots and hands out complete frames over valid/ready.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_i,
  input  logic [N_DIGITS-1:0]   anode_i,
  output logic [4*N_DIGITS-1:0] frame_data_o,
  output logic [N_DIGITS-1:0]   frame_blank_o,
  output logic                  frame_valid_o,
  input  logic                  frame_ready_i,
  output logic                  pattern_err_o,
  output logic                  overrun_o
);

  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic            cap_valid;
  logic [IdxW-1:0] cap_idx;
  logic [6:0]      cap_seg;
  seg_dec_t        cap_dec;

  seg7_sync_filter #(
    .N_DIGITS      (N_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES),
    .IDX_W         (IdxW)
  ) u_sync_filter (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_i       (seg_i),
    .anode_i     (anode_i),
    .cap_valid_o (cap_valid),
    .cap_idx_o   (cap_idx),
    .cap_seg_o   (cap_seg)
  );

  assign cap_dec = seg_to_hex(cap_seg);

  logic [4*N_DIGITS-1:0] slot_data_q, slot_data_d, frame_data_q, frame_data_d;
  logic [N_DIGITS-1:0]   slot_blank_q, slot_blank_d, frame_blank_q, frame_blank_d;
  logic [N_DIGITS-1:0]   mask_q, mask_d;
  logic                  valid_q, valid_d, overrun_q, overrun_d, err_q, err_d;
  logic                  complete, accept;

  assign complete = &mask_q;
  assign accept   = valid_q & frame_ready_i;

  always_comb begin
    slot_data_d   = slot_data_q;
    slot_blank_d  = slot_blank_q;
    mask_d        = mask_q;
    frame_data_d  = frame_data_q;
    frame_blank_d = frame_blank_q;
    valid_d       = valid_q;
    overrun_d     = overrun_q;
    err_d         = cap_valid & ~cap_dec.legal;

    // Clear before setting so a capture in the completion cycle starts the next frame.
    if (complete) mask_d = '0;
    if (cap_valid && cap_dec.legal) begin
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        if (cap_idx == IdxW'(k)) begin
          slot_data_d[4*k +: 4] = cap_dec.nibble;
          slot_blank_d[k]       = cap_dec.blank;
          mask_d[k]             = 1'b1;
        end
      end
    end

    if (accept) valid_d = 1'b0;
    if (complete) begin
      if (!valid_q || accept) begin
        frame_data_d  = slot_data_q;
        frame_blank_d = slot_blank_q;
        valid_d       = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_data_q   <= '0;
      slot_blank_q  <= '0;
      mask_q        <= '0;
      frame_data_q  <= '0;
      frame_blank_q <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      slot_data_q   <= slot_data_d;
      slot_blank_q  <= slot_blank_d;
      mask_q        <= mask_d;
      frame_data_q  <= frame_data_d;
      frame_blank_q <= frame_blank_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      err_q         <= err_d;
    end
  end

  assign frame_data_o  = frame_data_q;
  assign frame_blank_o = frame_blank_q;
  assign frame_valid_o = valid_q;
  assign pattern_err_o = err_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder (2 digits, 4-sample stability): expected frames
// are queued as stimulus is driven and compared when the DUT presents them.
module tb_seg7_scan_decoder;

  localparam int unsigned N = 2;

  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PC = 7'b1110010;
  localparam logic [6:0] PF = 7'b0111000;
  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] PX = 7'b1111110;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [6:0]     seg;
  logic [N-1:0]   anode;
  logic [4*N-1:0] frame_data;
  logic [N-1:0]   frame_blank;
  logic           frame_valid;
  logic           frame_ready;
  logic           pattern_err;
  logic           overrun;

  int tests_run    = 0;
  int tests_failed = 0;
  int hs_cnt       = 0;
  int err_cnt      = 0;

  logic [5*N-1:0] exp_q[$];  // {blank, data}

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .N_DIGITS      (N),
    .STABLE_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_i         (seg),
    .anode_i       (anode),
    .frame_data_o  (frame_data),
    .frame_blank_o (frame_blank),
    .frame_valid_o (frame_valid),
    .frame_ready_i (frame_ready),
    .pattern_err_o (pattern_err),
    .overrun_o     (overrun)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid && frame_ready) hs_cnt++;
      if (pattern_err) err_cnt++;
    end
  end

  task automatic drive(input logic [N-1:0] an, input logic [6:0] sg, input int n);
    @(posedge clk);
    #1;
    anode = an;
    seg   = sg;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!got) begin
        @(negedge clk);
        got = frame_valid;
      end
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    frame_ready = 1'b1;
    anode       = '1;
    seg         = PB;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (frame_data !== 8'h00) begin
      tests_failed++; $display("FAIL reset_data: got %h want 00", frame_data);
    end
    tests_run++;
    if (frame_blank !== 2'b00) begin
      tests_failed++; $display("FAIL reset_blank: got %b want 00", frame_blank);
    end
    tests_run++;
    if (frame_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b want 0", frame_valid);
    end
    tests_run++;
    if (pattern_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_err: got %b want 0", pattern_err);
    end
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++; $display("FAIL reset_overrun: got %b want 0", overrun);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame;
    bit got;
    int hs0;
    logic [5*N-1:0] e;
    hs0 = hs_cnt;
    exp_q.push_back({2'b00, 8'h32});
    drive(2'b10, P2, 6);
    drive(2'b01, P3, 6);
    wait_valid(got);
    e = exp_q.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL basic_frame: no frame_valid, want %h", e);
    end else if ({frame_blank, frame_data} !== e) begin
      tests_failed++; $display("FAIL basic_frame: got %h want %h", {frame_blank, frame_data}, e);
    end
    drive(2'b11, PB, 4);
    tests_run++;
    if (hs_cnt - hs0 != 1) begin
      tests_failed++; $display("FAIL basic_one_valid: got %0d handshakes want 1", hs_cnt - hs0);
    end
  endtask

  task automatic test_glitch;
    bit got;
    int hs0, e0;
    logic [5*N-1:0] e;
    hs0 = hs_cnt;
    e0  = err_cnt;
    exp_q.push_back({2'b00, 8'h71});
    drive(2'b10, P0, 2);
    drive(2'b10, P1, 6);
    drive(2'b01, P7, 6);
    wait_valid(got);
    e = exp_q.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL glitch_frame: no frame_valid, want %h", e);
    end else if ({frame_blank, frame_data} !== e) begin
      tests_failed++; $display("FAIL glitch_frame: got %h want %h", {frame_blank, frame_data}, e);
    end
    drive(2'b11, PB, 4);
    tests_run++;
    if (hs_cnt - hs0 != 1) begin
      tests_failed++; $display("FAIL glitch_one_valid: got %0d handshakes want 1", hs_cnt - hs0);
    end
    tests_run++;
    if (err_cnt != e0) begin
      tests_failed++; $display("FAIL glitch_no_err: got %0d err pulses want 0", err_cnt - e0);
    end
  endtask

  task automatic test_illegal;
    bit got;
    int hs0, e0;
    logic [5*N-1:0] e;
    hs0 = hs_cnt;
    e0  = err_cnt;
    drive(2'b10, P5, 6);
    drive(2'b01, PX, 6);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (err_cnt - e0 != 1) begin
      tests_failed++; $display("FAIL illegal_err_pulse: got %0d cycles want 1", err_cnt - e0);
    end
    tests_run++;
    if (hs_cnt != hs0 || frame_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_no_frame: got valid=%b hs=%0d want valid=0 hs=0",
               frame_valid, hs_cnt - hs0);
    end
    // Digit 0 must still be held in the mask; only digit 1 is recaptured.
    exp_q.push_back({2'b00, 8'hC5});
    drive(2'b01, PC, 6);
    wait_valid(got);
    e = exp_q.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL illegal_mask_kept: no frame_valid, want %h", e);
    end else if ({frame_blank, frame_data} !== e) begin
      tests_failed++;
      $display("FAIL illegal_mask_kept: got %h want %h", {frame_blank, frame_data}, e);
    end
    drive(2'b11, PB, 4);
    tests_run++;
    if (err_cnt - e0 != 1) begin
      tests_failed++; $display("FAIL illegal_err_total: got %0d want 1", err_cnt - e0);
    end
  endtask

  task automatic test_overrun;
    int hs0;
    logic [5*N-1:0] e;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    hs0 = hs_cnt;
    exp_q.push_back({2'b00, 8'hA5});
    drive(2'b10, P5, 6);
    drive(2'b01, PA, 6);
    drive(2'b10, PF, 6);
    drive(2'b01, P0, 6);
    repeat (4) @(negedge clk);
    tests_run++;
    if (frame_valid !== 1'b1) begin
      tests_failed++; $display("FAIL overrun_valid_held: got %b want 1", frame_valid);
    end
    tests_run++;
    if (frame_data !== 8'hA5 || frame_blank !== 2'b00) begin
      tests_failed++;
      $display("FAIL overrun_data_stable: got %h/%b want a5/00", frame_data, frame_blank);
    end
    tests_run++;
    if (overrun !== 1'b1) begin
      tests_failed++; $display("FAIL overrun_flag: got %b want 1", overrun);
    end
    tests_run++;
    if (hs_cnt != hs0) begin
      tests_failed++; $display("FAIL overrun_no_accept: got %0d handshakes want 0", hs_cnt - hs0);
    end
    @(posedge clk);
    #1;
    frame_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (frame_valid !== 1'b1 || {frame_blank, frame_data} !== e) begin
      tests_failed++;
      $display("FAIL overrun_accept: got valid=%b %h want valid=1 %h",
               frame_valid, {frame_blank, frame_data}, e);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (frame_valid !== 1'b0) begin
      tests_failed++; $display("FAIL overrun_valid_drop: got %b want 0", frame_valid);
    end
    tests_run++;
    if (overrun !== 1'b1) begin
      tests_failed++; $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_blank;
    bit got;
    int hs0, e0;
    logic [5*N-1:0] e;
    hs0 = hs_cnt;
    e0  = err_cnt;
    drive(2'b00, P8, 10);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (hs_cnt != hs0 || frame_valid !== 1'b0 || err_cnt != e0) begin
      tests_failed++;
      $display("FAIL multi_anode_no_capture: got valid=%b hs=%0d err=%0d want 0/0/0",
               frame_valid, hs_cnt - hs0, err_cnt - e0);
    end
    exp_q.push_back({2'b11, 8'h00});
    drive(2'b10, PB, 6);
    drive(2'b01, PB, 6);
    wait_valid(got);
    e = exp_q.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL blank_frame: no frame_valid, want %h", e);
    end else if ({frame_blank, frame_data} !== e) begin
      tests_failed++; $display("FAIL blank_frame: got %h want %h", {frame_blank, frame_data}, e);
    end
    drive(2'b11, PB, 4);
  endtask

  task automatic test_reset_mid_frame;
    bit got;
    int hs0;
    logic [5*N-1:0] e;
    drive(2'b10, P1, 6);
    @(posedge clk);
    #1;
    anode = '1;
    seg   = PB;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (frame_valid !== 1'b0 || pattern_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_flags: got valid=%b err=%b want 0/0", frame_valid, pattern_err);
    end
    tests_run++;
    if (frame_data !== 8'h00 || frame_blank !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_data: got %h/%b want 00/00", frame_data, frame_blank);
    end
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_overrun: got %b want 0", overrun);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hs0 = hs_cnt;
    drive(2'b01, P2, 6);
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (hs_cnt != hs0 || frame_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_mask_cleared: got valid=%b hs=%0d want 0/0",
               frame_valid, hs_cnt - hs0);
    end
    exp_q.push_back({2'b00, 8'h24});
    drive(2'b10, P4, 6);
    wait_valid(got);
    e = exp_q.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL midreset_recapture: no frame_valid, want %h", e);
    end else if ({frame_blank, frame_data} !== e) begin
      tests_failed++;
      $display("FAIL midreset_recapture: got %h want %h", {frame_blank, frame_data}, e);
    end
    drive(2'b11, PB, 4);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_illegal();
    test_overrun();
    test_blank();
    test_reset_mid_frame();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
